// File: rtl/spinvaders_pkg.sv
// Shared definitions for the space-invaders game controller: state encoding,
// default playfield geometry and score width.
package spinvaders_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_WIN  = 2'd2,
    ST_LOSE = 2'd3
  } game_state_e;

  localparam int SCORE_W     = 16;

  localparam int D_ROWS      = 3;
  localparam int D_COLS      = 5;
  localparam int D_X_W       = 10;
  localparam int D_COL_PITCH = 100;
  localparam int D_ROW_PITCH = 60;
  localparam int D_FORM_X0   = 30;
  localparam int D_FORM_Y0   = 30;
  localparam int D_X_MIN     = 10;
  localparam int D_X_MAX     = 630;
  localparam int D_SHIP_X0   = 400;
  localparam int D_SHIP_Y    = 400;
  localparam int D_SHIP_STEP = 5;
  localparam int D_SHOT_STEP = 10;
  localparam int D_MARCH_DIV = 8;
  localparam int D_MARCH_STEP = 10;
  localparam int D_DROP      = 20;
  localparam int D_HIT_HALF  = 10;
  localparam int D_LOSE_Y    = 380;
  localparam int D_POINTS    = 10;

  // Index width that never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spinvaders_game_ctrl_if.sv
// Button inputs and renderer-facing game state of the invaders controller.
interface spinvaders_game_ctrl_if
  import spinvaders_pkg::*;
#(
  parameter int ROWS = D_ROWS,
  parameter int COLS = D_COLS,
  parameter int X_W  = D_X_W
);
  logic                 tick;
  logic                 L;
  logic                 R;
  logic                 shoot;
  logic                 start;
  logic [ROWS*COLS-1:0] alive;
  logic [X_W-1:0]       formX;
  logic [X_W-1:0]       formY;
  logic [X_W-1:0]       shipX;
  logic [X_W-1:0]       shotX;
  logic [X_W-1:0]       shotY;
  logic                 shot_active;
  logic [SCORE_W-1:0]   score;
  logic [1:0]           state;

  modport master (
    output tick, L, R, shoot, start,
    input  alive, formX, formY, shipX, shotX, shotY, shot_active, score, state
  );

  modport slave (
    input  tick, L, R, shoot, start,
    output alive, formX, formY, shipX, shotX, shotY, shot_active, score, state
  );
endinterface

// File: rtl/spinvaders_hit_detect.sv
// Combinational projectile-vs-formation test; reports the lowest-index live
// invader whose hit box contains the shot.
module spinvaders_hit_detect
  import spinvaders_pkg::*;
#(
  parameter int ROWS      = D_ROWS,
  parameter int COLS      = D_COLS,
  parameter int X_W       = D_X_W,
  parameter int COL_PITCH = D_COL_PITCH,
  parameter int ROW_PITCH = D_ROW_PITCH,
  parameter int HIT_HALF  = D_HIT_HALF,
  localparam int N        = ROWS * COLS,
  localparam int IW       = idx_w(N)
) (
  input  logic [N-1:0]   alive,
  input  logic [X_W-1:0] form_x,
  input  logic [X_W-1:0] form_y,
  input  logic [X_W-1:0] shot_x,
  input  logic [X_W-1:0] shot_y,
  input  logic           shot_active,
  output logic           hit,
  output logic [IW-1:0]  hit_idx
);
  localparam int XW1 = X_W + 1;

  logic [N-1:0] hv;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [X_W-1:0] ix, iy, dx, dy;
      assign ix = form_x + X_W'(c * COL_PITCH);
      assign iy = form_y + X_W'(r * ROW_PITCH);
      assign dx = (shot_x >= ix) ? shot_x - ix : ix - shot_x;
      assign dy = (shot_y >= iy) ? shot_y - iy : iy - shot_y;
      assign hv[r*COLS+c] = alive[r*COLS+c] & shot_active &
                            ({1'b0, dx} <= XW1'(HIT_HALF)) &
                            ({1'b0, dy} <= XW1'(HIT_HALF));
    end
  end

  // Scan downward so the lowest matching index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (hv[i]) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/spinvaders_game_ctrl.sv
// Space-invaders game state: formation march/drop, ship, single projectile,
// kill scoring and win/lose sequencing. All state advances only on tick.
module spinvaders_game_ctrl
  import spinvaders_pkg::*;
#(
  parameter int ROWS       = D_ROWS,
  parameter int COLS       = D_COLS,
  parameter int X_W        = D_X_W,
  parameter int COL_PITCH  = D_COL_PITCH,
  parameter int ROW_PITCH  = D_ROW_PITCH,
  parameter int FORM_X0    = D_FORM_X0,
  parameter int FORM_Y0    = D_FORM_Y0,
  parameter int X_MIN      = D_X_MIN,
  parameter int X_MAX      = D_X_MAX,
  parameter int SHIP_X0    = D_SHIP_X0,
  parameter int SHIP_Y     = D_SHIP_Y,
  parameter int SHIP_STEP  = D_SHIP_STEP,
  parameter int SHOT_STEP  = D_SHOT_STEP,
  parameter int MARCH_DIV  = D_MARCH_DIV,
  parameter int MARCH_STEP = D_MARCH_STEP,
  parameter int DROP       = D_DROP,
  parameter int HIT_HALF   = D_HIT_HALF,
  parameter int LOSE_Y     = D_LOSE_Y,
  parameter int POINTS     = D_POINTS
) (
  input  logic                  Clk,
  input  logic                  reset,
  spinvaders_game_ctrl_if.slave io
);
  localparam int N   = ROWS * COLS;
  localparam int IW  = idx_w(N);
  localparam int CW  = idx_w(MARCH_DIV);
  localparam int XW1 = X_W + 1;

  logic [N-1:0]       alive_q, alive_d, alive_k;
  logic [X_W-1:0]     form_x_q, form_x_d, form_y_q, form_y_d;
  logic [X_W-1:0]     ship_x_q, ship_x_d, shot_x_q, shot_x_d, shot_y_q, shot_y_d;
  logic               shot_act_q, shot_act_d, dir_left_q, dir_left_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [SCORE_W-1:0] score_q, score_d;
  game_state_e        state_q, state_d;

  logic               hit;
  logic [IW-1:0]      hit_idx;
  logic [COLS-1:0]    col_live;
  logic [ROWS-1:0]    row_live;
  logic [X_W-1:0]     left_x, right_x, low_y;
  logic               at_edge;
  logic [SCORE_W:0]   score_sum;
  int                 low_r, hit_row;

  spinvaders_hit_detect #(
    .ROWS(ROWS), .COLS(COLS), .X_W(X_W),
    .COL_PITCH(COL_PITCH), .ROW_PITCH(ROW_PITCH), .HIT_HALF(HIT_HALF)
  ) u_hit (
    .alive(alive_q), .form_x(form_x_q), .form_y(form_y_q),
    .shot_x(shot_x_q), .shot_y(shot_y_q), .shot_active(shot_act_q),
    .hit(hit), .hit_idx(hit_idx)
  );

  // Post-kill occupancy drives both the march extents and the end check.
  always_comb begin
    alive_k = alive_q;
    for (int i = 0; i < N; i++)
      if (hit && hit_idx == IW'(i)) alive_k[i] = 1'b0;
    col_live = '0;
    row_live = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (alive_k[r*COLS+c]) begin
          col_live[c] = 1'b1;
          row_live[r] = 1'b1;
        end
    left_x  = form_x_q;
    right_x = form_x_q;
    low_r   = 0;
    for (int c = COLS - 1; c >= 0; c--)
      if (col_live[c]) left_x = form_x_q + X_W'(c * COL_PITCH);
    for (int c = 0; c < COLS; c++)
      if (col_live[c]) right_x = form_x_q + X_W'(c * COL_PITCH);
    for (int r = 0; r < ROWS; r++)
      if (row_live[r]) low_r = r;
    if (dir_left_q)
      at_edge = (|col_live) && ({1'b0, left_x} < XW1'(X_MIN + MARCH_STEP + HIT_HALF));
    else
      at_edge = (|col_live) && ({1'b0, right_x} + XW1'(MARCH_STEP + HIT_HALF) > XW1'(X_MAX));
    hit_row   = int'(hit_idx) / COLS;
    score_sum = {1'b0, score_q} + (SCORE_W+1)'(POINTS * (ROWS - hit_row));
  end

  always_comb begin
    alive_d    = alive_q;
    form_x_d   = form_x_q;
    form_y_d   = form_y_q;
    dir_left_d = dir_left_q;
    cnt_d      = cnt_q;
    ship_x_d   = ship_x_q;
    shot_x_d   = shot_x_q;
    shot_y_d   = shot_y_q;
    shot_act_d = shot_act_q;
    score_d    = score_q;
    state_d    = state_q;
    low_y      = '0;
    case (state_q)
      ST_IDLE: if (io.tick && io.start) begin
        alive_d    = '1;
        form_x_d   = X_W'(FORM_X0);
        form_y_d   = X_W'(FORM_Y0);
        dir_left_d = 1'b0;
        cnt_d      = '0;
        ship_x_d   = X_W'(SHIP_X0);
        shot_x_d   = '0;
        shot_y_d   = '0;
        shot_act_d = 1'b0;
        score_d    = '0;
        state_d    = ST_PLAY;
      end
      ST_WIN, ST_LOSE: if (io.tick && io.start) state_d = ST_IDLE;
      ST_PLAY: if (io.tick) begin
        alive_d = alive_k;
        if (hit) begin
          shot_act_d = 1'b0;
          score_d    = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        end else if (shot_act_q) begin
          if (shot_y_q < X_W'(SHOT_STEP)) shot_act_d = 1'b0;
          else                            shot_y_d   = shot_y_q - X_W'(SHOT_STEP);
        end else if (io.shoot) begin
          shot_act_d = 1'b1;
          shot_x_d   = ship_x_q;
          shot_y_d   = X_W'(SHIP_Y);
        end

        if (io.L && !io.R)
          ship_x_d = ({1'b0, ship_x_q} < XW1'(X_MIN + SHIP_STEP)) ?
                     X_W'(X_MIN) : ship_x_q - X_W'(SHIP_STEP);
        else if (io.R && !io.L)
          ship_x_d = ({1'b0, ship_x_q} + XW1'(SHIP_STEP) > XW1'(X_MAX)) ?
                     X_W'(X_MAX) : ship_x_q + X_W'(SHIP_STEP);

        if (cnt_q == CW'(MARCH_DIV - 1)) begin
          cnt_d = '0;
          if (at_edge) begin
            form_y_d   = form_y_q + X_W'(DROP);
            dir_left_d = ~dir_left_q;
          end else if (dir_left_q) begin
            form_x_d = form_x_q - X_W'(MARCH_STEP);
          end else begin
            form_x_d = form_x_q + X_W'(MARCH_STEP);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end

        low_y = form_y_d + X_W'(low_r * ROW_PITCH);
        if (alive_k == '0)                     state_d = ST_WIN;
        else if ({1'b0, low_y} >= XW1'(LOSE_Y)) state_d = ST_LOSE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      alive_q    <= '1;
      form_x_q   <= X_W'(FORM_X0);
      form_y_q   <= X_W'(FORM_Y0);
      dir_left_q <= 1'b0;
      cnt_q      <= '0;
      ship_x_q   <= X_W'(SHIP_X0);
      shot_x_q   <= '0;
      shot_y_q   <= '0;
      shot_act_q <= 1'b0;
      score_q    <= '0;
      state_q    <= ST_IDLE;
    end else begin
      alive_q    <= alive_d;
      form_x_q   <= form_x_d;
      form_y_q   <= form_y_d;
      dir_left_q <= dir_left_d;
      cnt_q      <= cnt_d;
      ship_x_q   <= ship_x_d;
      shot_x_q   <= shot_x_d;
      shot_y_q   <= shot_y_d;
      shot_act_q <= shot_act_d;
      score_q    <= score_d;
      state_q    <= state_d;
    end
  end

  assign io.alive       = alive_q;
  assign io.formX       = form_x_q;
  assign io.formY       = form_y_q;
  assign io.shipX       = ship_x_q;
  assign io.shotX       = shot_x_q;
  assign io.shotY       = shot_y_q;
  assign io.shot_active = shot_act_q;
  assign io.score       = score_q;
  assign io.state       = state_q;

endmodule

// File: tb/tb_spinvaders_game_ctrl.sv
// Bench for spinvaders_game_ctrl: three parameterisations share one set of
// button inputs; a behavioural game model checks the default one under random play.
module tb_spinvaders_game_ctrl;
  logic Clk = 1'b0, reset = 1'b0;
  logic tick = 1'b0, L = 1'b0, R = 1'b0, shoot = 1'b0, start = 1'b0;
  int nvec = 0, nmis = 0;

  always #5 Clk = ~Clk;

  spinvaders_game_ctrl_if #(.ROWS(3), .COLS(5), .X_W(10)) ifa ();
  spinvaders_game_ctrl_if #(.ROWS(3), .COLS(5), .X_W(10)) ifb ();
  spinvaders_game_ctrl_if #(.ROWS(1), .COLS(1), .X_W(10)) ifc ();

  assign ifa.tick = tick;  assign ifa.L = L;  assign ifa.R = R;
  assign ifa.shoot = shoot; assign ifa.start = start;
  assign ifb.tick = tick;  assign ifb.L = L;  assign ifb.R = R;
  assign ifb.shoot = shoot; assign ifb.start = start;
  assign ifc.tick = tick;  assign ifc.L = L;  assign ifc.R = R;
  assign ifc.shoot = shoot; assign ifc.start = start;

  spinvaders_game_ctrl u_a (.Clk(Clk), .reset(reset), .io(ifa.slave));
  spinvaders_game_ctrl #(.MARCH_DIV(1000)) u_b (.Clk(Clk), .reset(reset), .io(ifb.slave));
  spinvaders_game_ctrl #(.ROWS(1), .COLS(1), .MARCH_DIV(1000)) u_c
    (.Clk(Clk), .reset(reset), .io(ifc.slave));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input bit t, input bit l, input bit r, input bit sh, input bit st);
    @(negedge Clk);
    tick = t; L = l; R = r; shoot = sh; start = st;
    @(posedge Clk);
    #1;
    tick = 1'b0; L = 1'b0; R = 1'b0; shoot = 1'b0; start = 1'b0;
  endtask

  // ---------------- behavioural model of the default game ----------------
  bit m_al [3][5];
  int m_fx, m_fy, m_dir, m_cnt, m_sx, m_shx, m_shy, m_sact, m_score, m_st;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic m_field();
    for (int r = 0; r < 3; r++) for (int c = 0; c < 5; c++) m_al[r][c] = 1'b1;
    m_fx = 30; m_fy = 30; m_dir = 1; m_cnt = 0; m_sx = 400;
    m_shx = 0; m_shy = 0; m_sact = 0; m_score = 0;
  endtask

  task automatic m_reset();
    m_field();
    m_st = 0;
  endtask

  task automatic m_play(input bit l, input bit r, input bit sh);
    bit hit, any;
    int hr, hc, minc, maxc, lowr;
    hit = 0; hr = 0; hc = 0;
    for (int i = 0; i < 15; i++)
      if (!hit && m_al[i/5][i%5] && m_sact != 0 &&
          iabs(m_shx - (m_fx + (i%5)*100)) <= 10 && iabs(m_shy - (m_fy + (i/5)*60)) <= 10) begin
        hit = 1; hr = i/5; hc = i%5;
      end
    if (hit) begin
      m_al[hr][hc] = 1'b0; m_sact = 0;
      m_score = m_score + 10*(3 - hr);
      if (m_score > 65535) m_score = 65535;
    end else if (m_sact != 0) begin
      if (m_shy < 10) m_sact = 0; else m_shy = m_shy - 10;
    end else if (sh) begin
      m_sact = 1; m_shx = m_sx; m_shy = 400;
    end
    if (l && !r)      m_sx = (m_sx - 5 < 10) ? 10 : m_sx - 5;
    else if (r && !l) m_sx = (m_sx + 5 > 630) ? 630 : m_sx + 5;
    if (m_cnt == 7) begin
      m_cnt = 0; any = 0; minc = 5; maxc = -1;
      for (int c = 0; c < 5; c++) for (int rr = 0; rr < 3; rr++)
        if (m_al[rr][c]) begin
          any = 1;
          if (c < minc) minc = c;
          if (c > maxc) maxc = c;
        end
      if (any && ((m_dir > 0 && m_fx + maxc*100 + 10 + 10 > 630) ||
                  (m_dir < 0 && m_fx + minc*100 - 10 - 10 < 10))) begin
        m_fy = m_fy + 20; m_dir = -m_dir;
      end else m_fx = m_fx + 10*m_dir;
    end else m_cnt++;
    lowr = -1;
    for (int rr = 0; rr < 3; rr++) for (int c = 0; c < 5; c++) if (m_al[rr][c]) lowr = rr;
    if (lowr < 0) m_st = 2;
    else if (m_fy + lowr*60 >= 380) m_st = 3;
  endtask

  task automatic m_tick(input bit l, input bit r, input bit sh, input bit st);
    case (m_st)
      0: if (st) begin m_field(); m_st = 1; end
      1: m_play(l, r, sh);
      default: if (st) m_st = 0;
    endcase
  endtask

  function automatic logic [14:0] m_alive_vec();
    logic [14:0] v;
    v = '0;
    for (int r = 0; r < 3; r++) for (int c = 0; c < 5; c++) v[r*5+c] = m_al[r][c];
    return v;
  endfunction

  task automatic cmp_model();
    chk("alive", ifa.alive, m_alive_vec());
    chk("formX", ifa.formX, m_fx);
    chk("formY", ifa.formY, m_fy);
    chk("shipX", ifa.shipX, m_sx);
    chk("shotX", ifa.shotX, m_shx);
    chk("shotY", ifa.shotY, m_shy);
    chk("shot_active", ifa.shot_active, m_sact);
    chk("score", ifa.score, m_score);
    chk("state", ifa.state, m_st);
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    @(negedge Clk);
    reset = 1'b1;
    m_reset();
  endtask

  typedef struct {
    bit l; bit r; bit sh; bit st;
    int reps; int ship; int state;
  } vec_t;
  vec_t tbl [9];

  initial begin
    int n;
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b1,   1, 400, 1};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0,  78,  10, 1};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0,   2,  10, 1};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0,   5,  10, 1};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0,   6,  40, 1};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 118, 630, 1};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0,   3, 630, 1};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0,   4, 630, 1};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b1,   2, 630, 1};

    m_reset();
    @(negedge Clk); @(negedge Clk);
    reset = 1'b1;
    cmp_model();

    // Ship movement and clamping table
    do_reset();
    for (int i = 0; i < 9; i++) begin
      repeat (tbl[i].reps) cyc(1'b1, tbl[i].l, tbl[i].r, tbl[i].sh, tbl[i].st);
      chk("tbl_shipX", ifa.shipX, tbl[i].ship);
      chk("tbl_state", ifa.state, tbl[i].state);
    end

    // March and drop at the right edge
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 21; k++) begin
      repeat (7) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      if (k == 1) chk("march_hold", ifa.formX, 30);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("march_formX", ifa.formX, (k <= 19) ? 30 + 10*k : (k == 20 ? 220 : 210));
      chk("march_formY", ifa.formY, (k <= 19) ? 30 : 50);
    end

    // Kill scoring on the slow-march instance
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (6) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("kill_shipX", ifb.shipX, 430);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("kill_launchY", ifb.shotY, 400);
    chk("kill_launchX", ifb.shotX, 430);
    n = 0;
    while (ifb.alive[14] && n < 60) begin cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); n++; end
    chk("kill_ticks", n, 25);
    chk("kill_alive", ifb.alive, 15'h3fff);
    chk("kill_score", ifb.score, 10);
    chk("kill_shot_off", ifb.shot_active, 0);
    chk("kill_shotY", ifb.shotY, 160);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("kill_relaunch", ifb.shot_active, 1);

    // Single shot in flight ignores further shoot presses
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 41; k++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("single_active", ifb.shot_active, (k <= 40) ? 1 : 0);
      if (k % 10 == 0) chk("single_shotY", ifb.shotY, 400 - 10*k);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("single_relaunch", ifb.shot_active, 1);
    chk("single_relaunchY", ifb.shotY, 400);

    // Win on the 1x1 formation, then frozen until start
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (74) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("win_shipX", ifc.shipX, 30);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    n = 0;
    while (ifc.state != 2'd2 && n < 80) begin cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); n++; end
    chk("win_ticks", n, 37);
    chk("win_score", ifc.score, 10);
    chk("win_alive", ifc.alive, 0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("win_frozen_ship", ifc.shipX, 30);
    chk("win_frozen_shot", ifc.shot_active, 0);
    chk("win_frozen_state", ifc.state, 2);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("win_to_idle", ifc.state, 0);
    chk("win_idle_score", ifc.score, 10);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("win_restart_state", ifc.state, 1);
    chk("win_restart_score", ifc.score, 0);
    chk("win_restart_alive", ifc.alive, 1);

    // Asynchronous reset mid-flight and mid-march
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    n = 0;
    while (ifa.formY != 10'd70 && n < 500) begin cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); n++; end
    chk("arst_formY", ifa.formY, 70);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    n = 0;
    while (ifa.shotY != 10'd200 && n < 40) begin cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); n++; end
    chk("arst_shotY", ifa.shotY, 200);
    chk("arst_shot_on", ifa.shot_active, 1);
    #2 reset = 1'b0;
    #1;
    m_reset();
    cmp_model();
    @(negedge Clk);
    reset = 1'b1;

    // Random play against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit t, l, r, sh, st;
      t  = ($urandom_range(0, 3) != 0);
      l  = ($urandom_range(0, 9) < 4);
      r  = ($urandom_range(0, 9) < 4);
      sh = ($urandom_range(0, 9) < 3);
      st = ($urandom_range(0, 99) < 3);
      if (i == 1500) begin
        do_reset();
        cmp_model();
      end
      cyc(t, l, r, sh, st);
      if (t) m_tick(l, r, sh, st);
      cmp_model();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
